bus_burst_responder: RTL
========================

// Module: bus_burst_responder
// PURPOSE
//  Bus target (slave) for the burst bus that our DMA controller masters.
//  Decodes begin-transaction cycles aimed at its address window and serves
//  burst reads and writes from a local single-port word memory.
//  Sits between the shared bus and a local 32-bit SRAM (for example a
//  frame or feature buffer). Shares that SRAM with another user via memGrant.
// PARAMETERS
//  BASE_ADDRESS  32'h50000000  byte address of window start, aligned to window size
//  ADDRESS_BITS  9             local word-address width; window = 4*2^ADDRESS_BITS bytes
// PORTS
//  clock                  in   1   system clock
//  reset                  in   1   asynchronous, active-high reset
//  begin_transaction_in   in   1   master begin cycle
//  address_data_in        in   32  begin cycle: byte-swapped address; write: data
//  read_n_write_in        in   1   1 = read, 0 = write (valid on begin cycle)
//  burst_size_in          in   8   words-1 (valid on begin cycle)
//  byte_enables_in        in   4   write lane enables (valid on begin cycle)
//  data_valid_in          in   1   write data word present
//  end_transaction_in     in   1   master ends or aborts the transaction
//  address_data_out       out  32  read data
//  data_valid_out         out  1   read data word present
//  end_transaction_out    out  1   read burst complete
//  busy_out               out  1   write stall
//  error_out              out  1   transaction rejected
//  memAddress             out  ADDRESS_BITS  local word address
//  memDataOut             out  32  local write data
//  memByteEnables         out  4   local write lane enables
//  memWriteEnable         out  1   local write strobe
//  memDataIn              in   32  local read data, 1-cycle latency after memAddress
//  memGrant               in   1   local memory available this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all bus outputs, mem outputs and counters are 0.
//   Reset is asynchronous and may arrive mid-burst; the transfer is abandoned.
//  Address: addr = byteswap(address_data_in), i.e. {[7:0],[15:8],[23:16],[31:24]}.
//   Hit when addr[31:ADDRESS_BITS+2] == BASE_ADDRESS[31:ADDRESS_BITS+2].
//   On hit, latch ptr = addr[ADDRESS_BITS+1:2], count = burst_size_in+1 (9 bits),
//   byte enables and direction. A miss stays in IDLE and drives nothing.
//  FSM: IDLE, READ, RDONE, WRITE, ERROR.
//   IDLE  -> READ/WRITE on begin_transaction_in && hit. A begin outside IDLE is ignored.
//   READ  issue cycle: memGrant && issued<count -> memAddress=ptr; ptr++, issued++.
//         Next cycle: data_valid_out=1, address_data_out=memDataIn (registered).
//         memGrant low: no issue, bubble on data_valid_out.
//         After the last word is sent -> RDONE.
//         end_transaction_in (abort) -> IDLE immediately; no end_transaction_out.
//   RDONE end_transaction_out=1 for exactly 1 cycle -> IDLE.
//   WRITE busy_out = !memGrant (combinational).
//         Accept when data_valid_in && !busy_out && written<count:
//         memWriteEnable=1, memAddress=ptr, memDataOut=address_data_in,
//         memByteEnables=latched; ptr++, written++.
//         Words beyond count are dropped with no write.
//         end_transaction_in -> IDLE. A short burst is legal.
//   ERROR error_out=1 each cycle until end_transaction_in -> IDLE.
//  Latency: begin at T -> first memAddress at T+1 -> first data_valid_out at T+2,
//   given memGrant. A burst of N words completes with end_transaction_out at T+N+2.
//  ptr is ADDRESS_BITS wide and wraps modulo window (see CONFIGURATION).
//  memWriteEnable is 0 outside WRITE.
//  address_data_out is 0 whenever data_valid_out is 0.
// CONFIGURATION
//  BURST_BOUNDARY_CHECK_EN defined:
//   On a hit, when ptr+count > 2^ADDRESS_BITS, go IDLE -> ERROR.
//   No memory access occurs for that transaction.
//  BURST_BOUNDARY_CHECK_EN undefined:
//   No check is made and ptr wraps silently to 0. ERROR is unreachable
//   and error_out is tied 0.
// TESTING
//  Read 4 @0x50000010 (swapped 0x10000050), burst=3, memGrant=1 ->
//   memAddress 4,5,6,7; data_valid_out T+2..T+5; end_transaction_out at T+6.
//  Write 3 @0x50000000, burst=2, BE=4'hF, memGrant=1 ->
//   mem[0..2] written in 3 consecutive cycles; end_transaction_in -> IDLE.
//  Write with memGrant low for 2 cycles mid-burst ->
//   busy_out high for 2 cycles; no word lost or duplicated.
//  Begin @0x60000000 -> no response; all outputs stay 0.
//  Read 8 @word 508, check enabled -> error_out held until end_transaction_in.
//   Check disabled -> addresses 508..511,0..3.
//  Assert reset at the 2nd data word of a read ->
//   all outputs 0 immediately; the next begin is served normally.

Source files
------------

// File: rtl/bus_burst_responder.sv
// ---------------------------------------------------------------------------
// bus_burst_responder
//   Burst-bus target serving reads and writes from a local single-port word
//   SRAM. Begin cycles carry a byte-swapped byte address. A hit inside the
//   window starts a burst of burst_size_in+1 words.
//
//   Optional build macro: BURST_BOUNDARY_CHECK_EN
//     defined   : a burst that would run past the end of the window is
//                 rejected (error_out held until end_transaction_in)
//     undefined : the local word pointer wraps silently; error_out is 0
//
// Ports
//   clock, reset             clock, asynchronous active-high reset
//   begin_transaction_in     master begin cycle
//   address_data_in [31:0]   begin: byte-swapped address, write: data word
//   read_n_write_in          1 = read, 0 = write (begin cycle)
//   burst_size_in   [7:0]    words-1 (begin cycle)
//   byte_enables_in [3:0]    write lane enables (begin cycle)
//   data_valid_in            write data word present
//   end_transaction_in       master ends or aborts the transaction
//   address_data_out [31:0]  read data, 0 when data_valid_out is low
//   data_valid_out           read data word present
//   end_transaction_out      read burst complete (1 cycle)
//   busy_out                 write stall (local memory not granted)
//   error_out                transaction rejected
//   memAddress / memDataOut / memByteEnables / memWriteEnable
//                            local SRAM request side
//   memDataIn [31:0]         local SRAM read data, 1 cycle after memAddress
//   memGrant                 local SRAM available this cycle
// ---------------------------------------------------------------------------
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDRESS_BITS = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    begin_transaction_in,
  input  logic [31:0]             address_data_in,
  input  logic                    read_n_write_in,
  input  logic [7:0]              burst_size_in,
  input  logic [3:0]              byte_enables_in,
  input  logic                    data_valid_in,
  input  logic                    end_transaction_in,
  output logic [31:0]             address_data_out,
  output logic                    data_valid_out,
  output logic                    end_transaction_out,
  output logic                    busy_out,
  output logic                    error_out,
  output logic [ADDRESS_BITS-1:0] memAddress,
  output logic [31:0]             memDataOut,
  output logic [3:0]              memByteEnables,
  output logic                    memWriteEnable,
  input  logic [31:0]             memDataIn,
  input  logic                    memGrant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RDONE,
    S_WRITE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] ptr_q;
  logic [8:0]              count_q;
  logic [8:0]              done_q;     // words issued (read) or written (write)
  logic [3:0]              be_q;
  logic                    data_valid_q;

  // Byte-swapped address, word granularity only: bits [31:2] of
  // {a[7:0], a[15:8], a[23:16], a[31:24]}.
  logic [29:0]             word_addr;
  logic                    hit;
  logic                    start;
  logic [ADDRESS_BITS-1:0] ptr_new;
  logic [8:0]              count_new;
  logic                    crosses;
  logic                    issue;
  logic                    accept;

  assign word_addr = {address_data_in[7:0], address_data_in[15:8],
                      address_data_in[23:16], address_data_in[31:26]};
  assign hit       = (word_addr[29:ADDRESS_BITS] == BASE_ADDRESS[31:ADDRESS_BITS+2]);
  assign start     = (state_q == S_IDLE) && begin_transaction_in && hit;
  assign ptr_new   = word_addr[ADDRESS_BITS-1:0];
  assign count_new = {1'b0, burst_size_in} + 9'd1;

`ifdef BURST_BOUNDARY_CHECK_EN
  localparam int unsigned SPAN_W = ADDRESS_BITS + 10;
  localparam logic [SPAN_W-1:0] WINDOW_WORDS = SPAN_W'(1) << ADDRESS_BITS;
  logic [SPAN_W-1:0] span_end;
  assign span_end = SPAN_W'(ptr_new) + SPAN_W'(count_new);
  assign crosses  = (span_end > WINDOW_WORDS);
`else
  assign crosses  = 1'b0;
`endif

  // Read data is returned combinationally from the SRAM in the cycle after
  // the issue; data_valid_q marks that cycle and gates the bus to 0 otherwise.
  assign data_valid_out   = data_valid_q;
  assign address_data_out = data_valid_q ? memDataIn : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      done_q       <= '0;
      be_q         <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= issue;
      if (start) begin
        ptr_q   <= ptr_new;
        count_q <= count_new;
        done_q  <= '0;
        be_q    <= byte_enables_in;
      end else if (issue || accept) begin
        ptr_q  <= ptr_q + 1'b1;
        done_q <= done_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    issue               = 1'b0;
    accept              = 1'b0;
    end_transaction_out = 1'b0;
    busy_out            = 1'b0;
    error_out           = 1'b0;
    memAddress          = '0;
    memDataOut          = '0;
    memByteEnables      = '0;
    memWriteEnable      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (crosses)
            state_d = S_ERROR;
          else if (read_n_write_in)
            state_d = S_READ;
          else
            state_d = S_WRITE;
        end
      end

      S_READ: begin
        if (end_transaction_in) begin
          state_d = S_IDLE;
        end else begin
          if (memGrant && (done_q < count_q)) begin
            issue      = 1'b1;
            memAddress = ptr_q;
          end
          // Only one word is ever outstanding, so a valid word seen once every
          // word has been issued is the final one.
          if (data_valid_q && (done_q == count_q))
            state_d = S_RDONE;
        end
      end

      S_RDONE: begin
        end_transaction_out = 1'b1;
        state_d             = S_IDLE;
      end

      S_WRITE: begin
        busy_out = !memGrant;
        if (data_valid_in && memGrant && (done_q < count_q)) begin
          accept         = 1'b1;
          memWriteEnable = 1'b1;
          memAddress     = ptr_q;
          memDataOut     = address_data_in;
          memByteEnables = be_q;
        end
        if (end_transaction_in)
          state_d = S_IDLE;
      end

      S_ERROR: begin
`ifdef BURST_BOUNDARY_CHECK_EN
        error_out = 1'b1;
        if (end_transaction_in)
          state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
